// File: rtl/rf_pkg.sv
// Shared register-file writeback definitions: widths, request payload and lane helpers.
package rf_pkg;

   localparam int unsigned NUM_ARCH_REGS = 32;
   localparam int unsigned DATA_WIDTH    = 16;
   localparam int unsigned TAG_WIDTH     = 4;
   localparam int unsigned ADDR_WIDTH    = $clog2(NUM_ARCH_REGS);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  tag;
   } wb_req_t;

   // Number of active lanes in a 2-lane valid vector.
   function automatic logic [1:0] lane_count(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-grant round-robin picker; lane 1 skips requesters whose destination collides with lane 0.
module rr_pick2 #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned PTR_W      = 2
) (
   input  logic [NUM_REQ-1:0]            valid_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
   input  logic [PTR_W-1:0]              ptr_i,
   output logic                          lane0_vld_c,
   output logic [PTR_W-1:0]              lane0_idx_c,
   output logic                          lane1_vld_c,
   output logic [PTR_W-1:0]              lane1_idx_c,
   output logic [NUM_REQ-1:0]            grant_c
);

   localparam int unsigned SUM_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
   logic [SUM_W-1:0]      sum;
   logic [PTR_W-1:0]      idx;
   logic                  conflict;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i] = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // Scan from the pointer; register 0 never blocks, since it is never written.
   always_comb begin
      lane0_vld_c = 1'b0;
      lane0_idx_c = '0;
      lane1_vld_c = 1'b0;
      lane1_idx_c = '0;
      grant_c     = '0;
      sum         = '0;
      idx         = '0;
      conflict    = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_i} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (valid_i[idx]) begin
            if (!lane0_vld_c) begin
               lane0_vld_c  = 1'b1;
               lane0_idx_c  = idx;
               grant_c[idx] = 1'b1;
            end else if (!lane1_vld_c) begin
               conflict = (addr_a[idx] == addr_a[lane0_idx_c]) && (addr_a[idx] != '0);
               if (!conflict) begin
                  lane1_vld_c  = 1'b1;
                  lane1_idx_c  = idx;
                  grant_c[idx] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: grants up to two results per cycle to the register-file write ports
// and the 2-lane tag broadcast, with round-robin fairness.
module rf_wb_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = rf_pkg::DATA_WIDTH,
   parameter int unsigned TAG_WIDTH  = rf_pkg::TAG_WIDTH,
   parameter int unsigned ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          hlt,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [1:0]                    wr_en,
   output logic [ADDR_WIDTH-1:0]         wr_addr0,
   output logic [ADDR_WIDTH-1:0]         wr_addr1,
   output logic [DATA_WIDTH-1:0]         wr_data0,
   output logic [DATA_WIDTH-1:0]         wr_data1,
   output logic [1:0]                    cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag0,
   output logic [TAG_WIDTH-1:0]          cdb_tag1,
   output logic [DATA_WIDTH-1:0]         cdb_data0,
   output logic [DATA_WIDTH-1:0]         cdb_data1,
   output logic [15:0]                   grant_count
);

   import rf_pkg::*;

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = 16;

   logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
   logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
   logic [TAG_WIDTH-1:0]  tag_a  [NUM_REQ];

   logic [NUM_REQ-1:0] pick_valid;
   logic               lane0_vld, lane1_vld;
   logic [PTR_W-1:0]   lane0_idx, lane1_idx, last_idx;

   logic [1:0]            wr_en_d, wr_en_q;
   logic [1:0]            cdb_valid_d, cdb_valid_q;
   logic [ADDR_WIDTH-1:0] addr0_d, addr0_q, addr1_d, addr1_q;
   logic [DATA_WIDTH-1:0] data0_d, data0_q, data1_d, data1_q;
   logic [TAG_WIDTH-1:0]  tag0_d, tag0_q, tag1_d, tag1_q;
   logic [PTR_W-1:0]      rr_ptr_d, rr_ptr_q;
   logic [CNT_W-1:0]      grant_count_d, grant_count_q;
   logic [CNT_W:0]        cnt_sum;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign tag_a[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
   end

   // Halt hides every requester from the picker, so nothing is granted and the pointer holds.
   assign pick_valid = hlt ? '0 : req_valid;

   rr_pick2 #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_WIDTH (ADDR_WIDTH),
      .PTR_W      (PTR_W)
   ) u_pick (
      .valid_i     (pick_valid),
      .addr_i      (req_addr),
      .ptr_i       (rr_ptr_q),
      .lane0_vld_c (lane0_vld),
      .lane0_idx_c (lane0_idx),
      .lane1_vld_c (lane1_vld),
      .lane1_idx_c (lane1_idx),
      .grant_c     (req_ready)
   );

   assign last_idx = lane1_vld ? lane1_idx : lane0_idx;

   always_comb begin
      wr_en_d       = '0;
      cdb_valid_d   = '0;
      addr0_d       = addr0_q;
      addr1_d       = addr1_q;
      data0_d       = data0_q;
      data1_d       = data1_q;
      tag0_d        = tag0_q;
      tag1_d        = tag1_q;
      rr_ptr_d      = rr_ptr_q;
      grant_count_d = grant_count_q;
      cnt_sum       = '0;

      if (lane0_vld) begin
         cdb_valid_d[0] = 1'b1;
         wr_en_d[0]     = (addr_a[lane0_idx] != '0);
         addr0_d        = addr_a[lane0_idx];
         data0_d        = data_a[lane0_idx];
         tag0_d         = tag_a[lane0_idx];
      end
      if (lane1_vld) begin
         cdb_valid_d[1] = 1'b1;
         wr_en_d[1]     = (addr_a[lane1_idx] != '0);
         addr1_d        = addr_a[lane1_idx];
         data1_d        = data_a[lane1_idx];
         tag1_d         = tag_a[lane1_idx];
      end

      // Resume scanning just past the youngest grant, wrapping at NUM_REQ.
      if (lane0_vld) begin
         rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
      end

      cnt_sum = {1'b0, grant_count_q} + (CNT_W+1)'(lane_count({lane1_vld, lane0_vld}));
      grant_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q       <= '0;
         cdb_valid_q   <= '0;
         addr0_q       <= '0;
         addr1_q       <= '0;
         data0_q       <= '0;
         data1_q       <= '0;
         tag0_q        <= '0;
         tag1_q        <= '0;
         rr_ptr_q      <= '0;
         grant_count_q <= '0;
      end else begin
         wr_en_q       <= wr_en_d;
         cdb_valid_q   <= cdb_valid_d;
         addr0_q       <= addr0_d;
         addr1_q       <= addr1_d;
         data0_q       <= data0_d;
         data1_q       <= data1_d;
         tag0_q        <= tag0_d;
         tag1_q        <= tag1_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_count_q <= grant_count_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr0    = addr0_q;
   assign wr_addr1    = addr1_q;
   assign wr_data0    = data0_q;
   assign wr_data1    = data1_q;
   assign cdb_valid   = cdb_valid_q;
   assign cdb_tag0    = tag0_q;
   assign cdb_tag1    = tag1_q;
   assign cdb_data0   = data0_q;
   assign cdb_data1   = data1_q;
   assign grant_count = grant_count_q;

endmodule
